// File: rtl/wakeup_timer.sv
// -----------------------------------------------------------------------------
// wakeup_timer
// Fully synchronous programmable-compare wakeup timer for the always-on
// timer domain. After a load it counts ticks from 0 up to the captured compare
// value C. On a match it emits a one-cycle wakeup pulse and sets a sticky irq.
// In one-shot mode it then stops in DONE. In periodic mode it restarts from 0.
//
// Optional feature macro: WAKEUP_TIMER_PRESCALER_EN
//   Defined   : adds the prescale port. A tick occurs every prescale+1
//               enabled cycles in RUN.
//   Undefined : no prescale port. Every enabled cycle in RUN is a tick, which
//               is the same as prescale = 0.
//
// Ports:
//   clk      in   single clock, rising edge
//   clr      in   synchronous active-high reset, overrides everything
//   en       in   count enable (freezes counter and prescaler when low)
//   load     in   strobe: capture cmp/mode, clear count, enter RUN
//   cmp      in   compare value C (sampled on load)
//   mode     in   0 = one-shot, 1 = periodic (sampled on load)
//   prescale in   prescaler divider P (macro only, sampled live)
//   ack      in   clears irq (a match in the same cycle wins)
//   out      out  current count
//   wakeup   out  registered one-cycle match pulse
//   irq      out  sticky match flag
//   running  out  high while the timer is in RUN
// -----------------------------------------------------------------------------
module wakeup_timer #(
  parameter int WIDTH     = 17,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 load,
  input  logic [WIDTH-1:0]     cmp,
  input  logic                 mode,
`ifdef WAKEUP_TIMER_PRESCALER_EN
  input  logic [PRE_WIDTH-1:0] prescale,
`endif
  input  logic                 ack,
  output logic [WIDTH-1:0]     out,
  output logic                 wakeup,
  output logic                 irq,
  output logic                 running
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_r, state_nx;
  logic [WIDTH-1:0]     out_r, out_nx;
  logic [WIDTH-1:0]     cmp_r, cmp_nx;
  logic                 mode_r, mode_nx;
  logic                 wakeup_r, wakeup_nx;
  logic                 irq_r, irq_nx;
  logic                 running_r;
  logic [PRE_WIDTH-1:0] pre_r, pre_nx;
  logic [PRE_WIDTH-1:0] prescale_s;
  logic                 tick_s;

  // Without the prescaler option the divider is fixed at 0, so every enabled
  // cycle is a tick and the prescaler register stays at 0.
`ifdef WAKEUP_TIMER_PRESCALER_EN
  assign prescale_s = prescale;
`else
  assign prescale_s = {PRE_WIDTH{1'b0}};
`endif

  // A tick occurs when the prescaler has completed its prescale+1 cycle window.
  assign tick_s = en && (pre_r == prescale_s);

  // Next-state, counter, prescaler and flag logic.
  always_comb begin
    state_nx  = state_r;
    out_nx    = out_r;
    cmp_nx    = cmp_r;
    mode_nx   = mode_r;
    pre_nx    = pre_r;
    wakeup_nx = 1'b0;
    irq_nx    = irq_r;

    // ack is applied first, so a match below overrides it (set wins).
    if (ack) begin
      irq_nx = 1'b0;
    end else begin
      irq_nx = irq_r;
    end

    if (load) begin
      // A restart discards any match that would have happened this cycle.
      // irq is deliberately left alone.
      cmp_nx   = cmp;
      mode_nx  = mode;
      out_nx   = {WIDTH{1'b0}};
      pre_nx   = {PRE_WIDTH{1'b0}};
      state_nx = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx = ST_IDLE;
        end
        ST_RUN: begin
          if (en) begin
            if (tick_s) begin
              pre_nx = {PRE_WIDTH{1'b0}};
              // Compare happens before the increment, so out never wraps,
              // even when C is all-ones.
              if (out_r == cmp_r) begin
                wakeup_nx = 1'b1;
                irq_nx    = 1'b1;
                if (mode_r) begin
                  out_nx   = {WIDTH{1'b0}};
                  state_nx = ST_RUN;
                end else begin
                  out_nx   = out_r;
                  state_nx = ST_DONE;
                end
              end else begin
                out_nx = out_r + {{(WIDTH-1){1'b0}}, 1'b1};
              end
            end else begin
              pre_nx = pre_r + {{(PRE_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            // Paused: counter and prescaler both freeze.
            pre_nx = pre_r;
          end
        end
        ST_DONE: begin
          state_nx = ST_DONE;
        end
        default: begin
          state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r   <= ST_IDLE;
      out_r     <= {WIDTH{1'b0}};
      cmp_r     <= {WIDTH{1'b0}};
      mode_r    <= 1'b0;
      pre_r     <= {PRE_WIDTH{1'b0}};
      wakeup_r  <= 1'b0;
      irq_r     <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_nx;
      out_r     <= out_nx;
      cmp_r     <= cmp_nx;
      mode_r    <= mode_nx;
      pre_r     <= pre_nx;
      wakeup_r  <= wakeup_nx;
      irq_r     <= irq_nx;
      running_r <= (state_nx == ST_RUN);
    end
  end

  assign out     = out_r;
  assign wakeup  = wakeup_r;
  assign irq     = irq_r;
  assign running = running_r;

endmodule

// File: tb/tb_wakeup_timer.sv
// -----------------------------------------------------------------------------
// tb_wakeup_timer
// Self-checking bench for wakeup_timer. A vector table drives the default-width
// instance one clock per entry and checks out/wakeup/irq/running after each
// edge. Hand-written sequences cover the 4-bit all-ones compare case and, when
// WAKEUP_TIMER_PRESCALER_EN is defined, the prescaled period and the case of
// clr landing on the same edge as a match.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wakeup_timer;

  localparam int W  = 17;
  localparam int W4 = 4;

  logic         clk = 1'b0;
  logic         clr, en, load, mode, ack;
  logic [W-1:0] cmp;
  logic [W-1:0] out;
  logic         wakeup, irq, running;

  logic          clr4, en4, load4, mode4, ack4;
  logic [W4-1:0] cmp4;
  logic [W4-1:0] out4;
  logic          wakeup4, irq4, running4;

`ifdef WAKEUP_TIMER_PRESCALER_EN
  logic [3:0] prescale;
  logic [3:0] prescale4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wakeup_timer #(.WIDTH(W), .PRE_WIDTH(4)) dut (
    .clk(clk), .clr(clr), .en(en), .load(load), .cmp(cmp), .mode(mode),
`ifdef WAKEUP_TIMER_PRESCALER_EN
    .prescale(prescale),
`endif
    .ack(ack), .out(out), .wakeup(wakeup), .irq(irq), .running(running)
  );

  wakeup_timer #(.WIDTH(W4), .PRE_WIDTH(4)) dut4 (
    .clk(clk), .clr(clr4), .en(en4), .load(load4), .cmp(cmp4), .mode(mode4),
`ifdef WAKEUP_TIMER_PRESCALER_EN
    .prescale(prescale4),
`endif
    .ack(ack4), .out(out4), .wakeup(wakeup4), .irq(irq4), .running(running4)
  );

  typedef struct {
    logic         clr;
    logic         load;
    logic         en;
    logic [W-1:0] cmp;
    logic         mode;
    logic         ack;
    logic [W-1:0] exp_out;
    logic         exp_wk;
    logic         exp_irq;
    logic         exp_run;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic c, input logic l, input logic e,
                              input int cv, input logic m, input logic a,
                              input int eo, input logic ew, input logic ei,
                              input logic er);
    vec_t v;
    v.clr = c; v.load = l; v.en = e; v.cmp = W'(cv); v.mode = m; v.ack = a;
    v.exp_out = W'(eo); v.exp_wk = ew; v.exp_irq = ei; v.exp_run = er;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int n;
    clr = 1'b1; en = 1'b0; load = 1'b0; mode = 1'b0; ack = 1'b0;
    cmp = '0;
    clr4 = 1'b1; en4 = 1'b0; load4 = 1'b0; mode4 = 1'b0; ack4 = 1'b0;
    cmp4 = '0;
`ifdef WAKEUP_TIMER_PRESCALER_EN
    prescale = 4'd0;
    prescale4 = 4'd0;
`endif

    // ---- vector table: clr load en cmp mode ack | out wk irq run ----
    // Reset with load held high
    add(1,1,1,5,0,0, 0,0,0,0);
    add(1,1,1,5,0,0, 0,0,0,0);
    // One-shot C=5
    add(0,1,1,5,0,0, 0,0,0,1);
    for (int i = 1; i <= 5; i++) add(0,0,1,0,0,0, i,0,0,1);
    add(0,0,1,0,0,0, 5,1,1,0);
    for (int i = 0; i < 48; i++) add(0,0,1,0,0,0, 5,0,1,0);
    // Periodic C=3, irq survives load, ack clears, match beats ack
    add(0,1,1,3,1,0, 0,0,1,1);
    add(0,0,1,0,0,0, 1,0,1,1);
    add(0,0,1,0,0,0, 2,0,1,1);
    add(0,0,1,0,0,0, 3,0,1,1);
    add(0,0,1,0,0,0, 0,1,1,1);
    add(0,0,1,0,0,1, 1,0,0,1);
    add(0,0,1,0,0,1, 2,0,0,1);
    add(0,0,1,0,0,1, 3,0,0,1);
    add(0,0,1,0,0,1, 0,1,1,1);
    add(0,0,1,0,0,1, 1,0,0,1);
    // Pause at out=4 for 7 cycles, then reload C=2 at out=8
    add(0,1,1,10,1,0, 0,0,0,1);
    for (int i = 1; i <= 4; i++) add(0,0,1,0,0,0, i,0,0,1);
    for (int i = 0; i < 7; i++) add(0,0,0,0,0,0, 4,0,0,1);
    for (int i = 5; i <= 8; i++) add(0,0,1,0,0,0, i,0,0,1);
    add(0,1,1,2,1,0, 0,0,0,1);
    add(0,0,1,0,0,0, 1,0,0,1);
    add(0,0,1,0,0,0, 2,0,0,1);
    add(0,0,1,0,0,0, 0,1,1,1);
    add(0,0,1,0,0,0, 1,0,1,1);
    add(0,0,1,0,0,0, 2,0,1,1);
    // clr on the match edge wins, then IDLE ignores en
    add(1,0,1,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,0, 0,0,0,0);
    // Load on the match edge discards the match
    add(0,1,1,1,0,0, 0,0,0,1);
    add(0,0,1,0,0,0, 1,0,0,1);
    add(0,1,1,4,1,0, 0,0,0,1);
    add(0,0,1,0,0,0, 1,0,0,1);
    // C=0 periodic: wakeup held high
    add(0,1,1,0,1,0, 0,0,0,1);
    for (int i = 0; i < 5; i++) add(0,0,1,0,0,0, 0,1,1,1);
    add(0,0,0,0,0,0, 0,0,1,1);
    add(0,0,1,0,0,1, 0,1,1,1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clr = vecs[i].clr; load = vecs[i].load; en = vecs[i].en;
      cmp = vecs[i].cmp; mode = vecs[i].mode; ack = vecs[i].ack;
      @(posedge clk);
      #1;
      check($sformatf("v%0d out", i), 32'(out), 32'(vecs[i].exp_out));
      check($sformatf("v%0d wakeup", i), 32'(wakeup), 32'(vecs[i].exp_wk));
      check($sformatf("v%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      check($sformatf("v%0d running", i), 32'(running), 32'(vecs[i].exp_run));
    end

    // ---- 4-bit instance, C=15 periodic: reaches all-ones, no wrap ----
    @(negedge clk);
    clr4 = 1'b0; load4 = 1'b1; cmp4 = 4'd15; mode4 = 1'b1; en4 = 1'b1;
    @(posedge clk); #1;
    check("w4 load out", 32'(out4), 32'd0);
    check("w4 load running", 32'(running4), 32'd1);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      load4 = 1'b0;
      @(posedge clk); #1;
      check($sformatf("w4 out%0d", i), 32'(out4), 32'(i));
      check($sformatf("w4 wk%0d", i), 32'(wakeup4), 32'd0);
    end
    @(posedge clk); #1;
    check("w4 match out", 32'(out4), 32'd0);
    check("w4 match wakeup", 32'(wakeup4), 32'd1);
    check("w4 match irq", 32'(irq4), 32'd1);
    @(posedge clk); #1;
    check("w4 after out", 32'(out4), 32'd1);
    check("w4 after wakeup", 32'(wakeup4), 32'd0);

`ifdef WAKEUP_TIMER_PRESCALER_EN
    // ---- prescale=2, C=3 periodic: period 12 cycles ----
    @(negedge clk);
    clr = 1'b0; load = 1'b1; cmp = W'(3); mode = 1'b1; en = 1'b1; ack = 1'b0;
    prescale = 4'd2;
    @(posedge clk); #1;
    @(negedge clk);
    load = 1'b0;
    for (int p = 0; p < 2; p++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!wakeup && n < 40);
      check($sformatf("pre period%0d", p), 32'(n), 32'd12);
    end
    // clr lands on the edge of the next match
    repeat (11) @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk); #1;
    check("clr-match wakeup", 32'(wakeup), 32'd0);
    check("clr-match out", 32'(out), 32'd0);
    check("clr-match irq", 32'(irq), 32'd0);
    check("clr-match running", 32'(running), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
